// File: rtl/coeff_stream_reader_pkg.sv
// Shared FFT coefficient-bus definitions: default sizes, packed-entry layout,
// saturating negate and the reader FSM states.
package coeff_stream_reader_pkg;

  localparam int unsigned DefNbits = 9;
  localparam int unsigned DefN     = 8;

  typedef enum logic [0:0] {
    StIdle,
    StStream
  } state_e;

  // LSB offset of entry k in the packed bus; the coefficient ROM packs with the same layout.
  function automatic int unsigned entry_slice(input int unsigned k, input int unsigned nbits);
    return k * 2 * nbits;
  endfunction

  // Negate within an nbits-wide two's-complement field; the most-negative value clamps to max.
  function automatic int sat_neg(input int val, input int unsigned nbits);
    int lim;
    lim = 1 << (nbits - 1);
    if (val <= -lim) begin
      return lim - 1;
    end
    return -val;
  endfunction

endpackage

// File: rtl/coeff_stream_reader_if.sv
// Coefficient output stream: valid/ready handshake plus the unpacked complex value.
interface coeff_stream_reader_if
  import coeff_stream_reader_pkg::*;
#(
  parameter int unsigned NBITS = DefNbits,
  parameter int unsigned N     = DefN
);
  localparam int unsigned IdxW = $clog2(N);

  logic             out_valid;
  logic             out_ready;
  logic [NBITS-1:0] out_re;
  logic [NBITS-1:0] out_im;
  logic [IdxW-1:0]  out_idx;
  logic             out_last;

  modport master (
    output out_valid,
    input  out_ready,
    output out_re,
    output out_im,
    output out_idx,
    output out_last
  );

  modport slave (
    input  out_valid,
    output out_ready,
    input  out_re,
    input  out_im,
    input  out_idx,
    input  out_last
  );
endinterface

// File: rtl/coeff_stream_reader_unpack.sv
// Combinational selector: picks entry idx from the snapshot and optionally conjugates it.
module coeff_stream_reader_unpack
  import coeff_stream_reader_pkg::*;
#(
  parameter int unsigned NBITS = DefNbits,
  parameter int unsigned N     = DefN,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [NBITS*N*2-1:0] snap_i,
  input  logic [IdxW-1:0]      idx_i,
  input  logic                 conj_i,
  output logic [NBITS-1:0]     re_o,
  output logic [NBITS-1:0]     im_o
);

  logic [2*NBITS-1:0] entry;
  logic [NBITS-1:0]   im_raw;

  // Slice the selected entry; real part is the upper half, imag the lower half.
  always_comb begin
    entry  = snap_i[entry_slice(32'(idx_i), NBITS) +: 2*NBITS];
    re_o   = entry[2*NBITS-1:NBITS];
    im_raw = entry[NBITS-1:0];
    im_o   = conj_i ? NBITS'(sat_neg(int'($signed(im_raw)), NBITS)) : im_raw;
  end

endmodule

// File: rtl/coeff_stream_reader.sv
// Streams the N packed twiddle coefficients of a snapshotted bus word, one per handshake.
module coeff_stream_reader
  import coeff_stream_reader_pkg::*;
#(
  parameter int unsigned NBITS = DefNbits,
  parameter int unsigned N     = DefN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NBITS*N*2-1:0] coeff_data,
  input  logic                 start,
  input  logic                 conj,
  output logic                 busy,
  output logic                 done,
  coeff_stream_reader_if.master out_if
);

  localparam int unsigned IdxW = $clog2(N);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  state_e               state_q, state_d;
  logic [NBITS*N*2-1:0] snap_q, snap_d;
  logic                 conj_q, conj_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NBITS-1:0]     re_q, re_d;
  logic [NBITS-1:0]     im_q, im_d;

  // Output data is looked up from next-state snapshot/index so it lands in step with valid.
  coeff_stream_reader_unpack #(
    .NBITS(NBITS),
    .N    (N)
  ) u_coeff_unpack (
    .snap_i(snap_d),
    .idx_i (idx_d),
    .conj_i(conj_d),
    .re_o  (re_d),
    .im_o  (im_d)
  );

  // Next-state: accept start when idle, advance index on each handshake, finish after N-1.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    conj_d  = conj_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          snap_d  = coeff_data;
          conj_d  = conj;
          idx_d   = '0;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = StStream;
        end
      end
      StStream: begin
        if (valid_q && out_if.out_ready) begin
          if (idx_q == LastIdx) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    last_d = valid_d && (idx_d == LastIdx);
  end

  // State and registered outputs; synchronous reset wins over any same-cycle start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      conj_q  <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      re_q    <= '0;
      im_q    <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      conj_q  <= conj_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      re_q    <= re_d;
      im_q    <= im_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign out_if.out_valid  = valid_q;
  assign out_if.out_re     = re_q;
  assign out_if.out_im     = im_q;
  assign out_if.out_idx    = idx_q;
  assign out_if.out_last   = last_q;

endmodule

// File: tb/tb_coeff_stream_reader.sv
// Scoreboard bench for coeff_stream_reader: stimulus pushes expected coefficients,
// a negedge monitor pops and compares on every handshake.
module tb_coeff_stream_reader;

  localparam int NB = 9;
  localparam int NC = 8;
  localparam int W  = NB * NC * 2;
  localparam int MaxPos = (1 << (NB - 1)) - 1;

  typedef struct {
    int re;
    int im;
    int idx;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] coeff_data = '0;
  logic         start = 1'b0;
  logic         conj = 1'b0;
  logic         busy;
  logic         done;

  coeff_stream_reader_if #(.NBITS(NB), .N(NC)) out_if ();

  coeff_stream_reader #(
    .NBITS(NB),
    .N    (NC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .coeff_data(coeff_data),
    .start     (start),
    .conj      (conj),
    .busy      (busy),
    .done      (done),
    .out_if    (out_if)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];

  function automatic int sx(input logic [NB-1:0] v);
    int r;
    r = int'(v);
    if (r > MaxPos) r -= (1 << NB);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: entry k sits at bit k*2*NB, re above im; conj negates im, clamping at max.
  task automatic push_run(input logic [W-1:0] bus, input bit cj);
    logic [W-1:0] tmp;
    exp_t e;
    for (int k = 0; k < NC; k++) begin
      tmp   = bus >> (k * 2 * NB);
      e.re  = sx(tmp[2*NB-1:NB]);
      e.im  = sx(tmp[NB-1:0]);
      e.idx = k;
      if (cj) begin
        e.im = -e.im;
        if (e.im > MaxPos) e.im = MaxPos;
      end
      exp_q.push_back(e);
    end
    exp_done++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int exp_cycles);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 300) begin
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    if (seen && exp_cycles >= 0) chk({name, "_cycles_to_done"}, n, exp_cycles);
  endtask

  function automatic logic [W-1:0] rand_bus();
    logic [W-1:0] b;
    for (int k = 0; k < NC; k++) b[k*2*NB +: 2*NB] = (2*NB)'($urandom);
    return b;
  endfunction

  // Downstream ready: 0 = always, 1 = pattern 1,0,0 repeating, 2 = random.
  initial begin : ready_drv
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: out_if.out_ready = 1'b1;
        1: begin
          out_if.out_ready = (ph == 0);
          ph = (ph + 1) % 3;
        end
        default: out_if.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each handshake against the scoreboard, check stall hold and done shape.
  initial begin : monitor
    exp_t e;
    bit   stalled;
    int   s_re, s_im, s_idx, s_last;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (out_if.out_valid !== 1'b1 || sx(out_if.out_re) != s_re ||
              sx(out_if.out_im) != s_im || int'(out_if.out_idx) != s_idx ||
              int'(out_if.out_last) != s_last) begin
            failures++;
            $display("FAIL stall_hold: got v=%0b re=%0d im=%0d idx=%0d last=%0b, held re=%0d im=%0d idx=%0d last=%0d",
                     out_if.out_valid, sx(out_if.out_re), sx(out_if.out_im), out_if.out_idx,
                     out_if.out_last, s_re, s_im, s_idx, s_last);
          end
        end
        stalled = 1'b0;
        if (out_if.out_valid === 1'b1) begin
          if (out_if.out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_valid: got idx=%0d re=%0d, expected no output",
                       out_if.out_idx, sx(out_if.out_re));
            end else begin
              e = exp_q.pop_front();
              if (sx(out_if.out_re) != e.re || sx(out_if.out_im) != e.im ||
                  int'(out_if.out_idx) != e.idx ||
                  int'(out_if.out_last) != int'(e.idx == NC - 1)) begin
                failures++;
                $display("FAIL coeff: got re=%0d im=%0d idx=%0d last=%0b, expected re=%0d im=%0d idx=%0d last=%0d",
                         sx(out_if.out_re), sx(out_if.out_im), out_if.out_idx, out_if.out_last,
                         e.re, e.im, e.idx, int'(e.idx == NC - 1));
              end
            end
          end else begin
            stalled = 1'b1;
            s_re    = sx(out_if.out_re);
            s_im    = sx(out_if.out_im);
            s_idx   = int'(out_if.out_idx);
            s_last  = int'(out_if.out_last);
          end
        end
        if (done === 1'b1) begin
          done_cnt++;
          checks++;
          if (out_if.out_last !== 1'b0 || out_if.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL done_overlap: got last=%0b valid=%0b with done, expected 0 0",
                     out_if.out_last, out_if.out_valid);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [W-1:0] bus;
    logic [W-1:0] bus2;
    bit           cj;
    int           dc;
    int           n;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_if.out_valid), 0);
    chk("rst_last", int'(out_if.out_last), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_re", int'(out_if.out_re), 0);
    chk("rst_im", int'(out_if.out_im), 0);
    chk("rst_idx", int'(out_if.out_idx), 0);

    // Basic stream: re=k+1, im=-(k+1), ready held high
    for (int k = 0; k < NC; k++) bus[k*2*NB +: 2*NB] = {NB'(k + 1), NB'(-(k + 1))};
    coeff_data = bus;
    conj = 1'b0;
    ready_mode = 0;
    tick();
    push_run(bus, 1'b0);
    pulse_start();
    chk("t1_first_valid", int'(out_if.out_valid), 1);
    chk("t1_first_busy", int'(busy), 1);
    chk("t1_first_idx", int'(out_if.out_idx), 0);
    wait_done("t1", NC);
    chk("t1_drained", exp_q.size(), 0);

    // Backpressure 1,0,0 pattern
    ready_mode = 1;
    tick();
    push_run(bus, 1'b0);
    pulse_start();
    wait_done("t2", -1);
    chk("t2_drained", exp_q.size(), 0);

    // Conjugate saturation: entry 3 = {-256,-256}, entry 5 im = +5
    bus = rand_bus();
    bus[3*2*NB +: 2*NB] = {NB'(-256), NB'(-256)};
    bus[5*2*NB + NB +: NB] = NB'(17);
    bus[5*2*NB +: NB] = NB'(5);
    coeff_data = bus;
    conj = 1'b1;
    ready_mode = 2;
    push_run(bus, 1'b1);
    pulse_start();
    conj = 1'b0;
    wait_done("t3", -1);
    chk("t3_drained", exp_q.size(), 0);

    // Snapshot isolation and start-while-busy
    bus = rand_bus();
    coeff_data = bus;
    conj = 1'b0;
    ready_mode = 1;
    push_run(bus, 1'b0);
    pulse_start();
    tick();
    tick();
    coeff_data = ~bus;
    conj = 1'b1;
    pulse_start();
    wait_done("t4a", -1);
    chk("t4a_drained", exp_q.size(), 0);
    // Start in the done cycle: accepted on the very next edge
    bus2 = rand_bus();
    coeff_data = bus2;
    conj = 1'b0;
    push_run(bus2, 1'b0);
    pulse_start();
    chk("t4b_start_in_done_valid", int'(out_if.out_valid), 1);
    chk("t4b_start_in_done_idx", int'(out_if.out_idx), 0);
    wait_done("t4b", -1);
    repeat (10) tick();
    chk("t4_no_extra_run", int'(out_if.out_valid), 0);
    chk("t4b_drained", exp_q.size(), 0);

    // Reset mid-run at idx 4
    bus = rand_bus();
    coeff_data = bus;
    ready_mode = 0;
    push_run(bus, 1'b0);
    pulse_start();
    n = 0;
    while (!(out_if.out_valid === 1'b1 && out_if.out_idx == 4) && n < 20) begin
      tick();
      n++;
    end
    chk("t5_reached_idx4", int'(out_if.out_idx), 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    exp_done--;
    dc = done_cnt;
    chk("t5_busy", int'(busy), 0);
    chk("t5_valid", int'(out_if.out_valid), 0);
    chk("t5_idx", int'(out_if.out_idx), 0);
    repeat (20) tick();
    chk("t5_no_done", done_cnt - dc, 0);
    chk("t5_no_valid", int'(out_if.out_valid), 0);
    bus = rand_bus();
    coeff_data = bus;
    ready_mode = 2;
    push_run(bus, 1'b0);
    pulse_start();
    chk("t5_restart_idx", int'(out_if.out_idx), 0);
    wait_done("t5", -1);

    // Simultaneous reset and start
    tick();
    coeff_data = rand_bus();
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    chk("t6_valid", int'(out_if.out_valid), 0);
    chk("t6_busy", int'(busy), 0);
    repeat (3) tick();
    chk("t6_still_idle", int'(out_if.out_valid), 0);

    // Randomized runs
    repeat (8) begin
      bus = rand_bus();
      if ($urandom_range(0, 1) == 1)
        bus[$urandom_range(0, NC - 1) * 2 * NB +: NB] = NB'(-256);
      cj = 1'($urandom_range(0, 1));
      coeff_data = bus;
      conj = cj;
      ready_mode = $urandom_range(0, 2);
      push_run(bus, cj);
      pulse_start();
      coeff_data = rand_bus();
      wait_done("rand", -1);
      tick();
    end
    chk("rand_drained", exp_q.size(), 0);

    repeat (3) tick();
    chk("done_count", done_cnt, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
